// File: rtl/net_packet_rx_pkg.sv
// Shared network packet types and widths for the core-side receiver.
// Also holds the receiver FSM state encoding.
package net_packet_rx_pkg;

  localparam int imem_addr_width_gp = 10;
  localparam int rs_imm_size_gp     = 5;
  localparam int mask_length_gp     = 8;

  typedef enum logic [2:0] {
    NULL  = 3'd0,
    INSTR = 3'd1,
    REG   = 3'd2,
    PC    = 3'd3,
    BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs_imm;
  } instruction_s;

  typedef struct packed {
    logic [9:0]  ID;
    net_op_e     net_op;
    logic [31:0] net_data;
    logic [15:0] net_addr;
  } net_packet_s;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    RUN
  } net_rx_state_e;

endpackage

// File: rtl/net_rx_fifo.sv
// Small synchronous FIFO buffering INSTR writes toward the imem.
// depth_p must be a power of 2 so the pointers wrap naturally.
module net_rx_fifo #(
  parameter int width_p = 26,
  parameter int depth_p = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int aw = $clog2(depth_p);
  localparam logic [aw:0] depth_c = (aw+1)'(depth_p);

  logic [aw-1:0]      wr_q, rd_q;
  logic [aw:0]        cnt_q, cnt_d;
  logic [width_p-1:0] mem_q [depth_p];
  logic               do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == depth_c);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/net_packet_rx.sv
// Core-side network receiver: decodes boot/load packets into write strobes.
// Define NET_RX_STATS_EN to build the INSTR/REG statistics counters.
module net_packet_rx
  import net_packet_rx_pkg::*;
#(
  parameter logic [9:0] net_ID_p          = 10'b1,
  parameter int         imem_addr_width_p = imem_addr_width_gp,
  parameter int         fifo_depth_p      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [$bits(net_packet_s)-1:0]  net_packet_flat_i,
  output logic [$bits(net_packet_s)-1:0]  net_packet_flat_o,
  output logic                            imem_wen_o,
  input  logic                            imem_ready_i,
  output logic [imem_addr_width_p-1:0]    imem_addr_o,
  output logic [$bits(instruction_s)-1:0] imem_data_o,
  output logic                            rf_wen_o,
  output logic [rs_imm_size_gp-1:0]       rf_addr_o,
  output logic [31:0]                     rf_data_o,
  output logic [mask_length_gp-1:0]       barrier_mask_o,
  output logic                            pc_wen_o,
  output logic [imem_addr_width_p-1:0]    pc_o,
  output logic                            running_o,
  output logic                            err_o,
  output logic [15:0]                     instr_count_o,
  output logic [15:0]                     reg_count_o
);

  localparam int iw = $bits(instruction_s);
  localparam int fw = imem_addr_width_p + iw;

  net_packet_s   pkt_q, fwd_q, fwd_d;
  net_rx_state_e state_q, state_d;
  logic          match, in_run;
  logic          is_instr, is_reg, is_pc, is_bar;
  logic          push, pop, drop;
  logic          fifo_full, fifo_empty;
  logic [fw-1:0] fifo_head;
  logic          pc_wen_q, pc_wen_d;
  logic          rf_wen_q, running_q, err_q;
  logic [rs_imm_size_gp-1:0]    rf_addr_q;
  logic [31:0]                  rf_data_q;
  logic [mask_length_gp-1:0]    mask_q;
  logic [imem_addr_width_p-1:0] pc_q;
  logic                         unused_addr_bits;

  assign match    = (pkt_q.ID == net_ID_p) && (pkt_q.net_op != NULL);
  assign is_instr = match && (pkt_q.net_op == INSTR);
  assign is_reg   = match && (pkt_q.net_op == REG);
  assign is_pc    = match && (pkt_q.net_op == PC);
  assign is_bar   = match && (pkt_q.net_op == BAR);
  assign in_run   = (state_q == RUN);

  assign pop  = ~fifo_empty & imem_ready_i;
  assign push = is_instr & ~in_run;
  assign drop = push & fifo_full & ~pop;

  assign fwd_d = (!match && pkt_q.net_op != NULL) ? pkt_q : '0;
  assign unused_addr_bits = ^pkt_q.net_addr;

  net_rx_fifo #(
    .width_p (fw),
    .depth_p (fifo_depth_p)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({pkt_q.net_addr[imem_addr_width_p-1:0],
               pkt_q.net_data[iw-1:0]}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    pc_wen_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_pc) state_d = START;
        else if (is_instr | is_reg | is_bar) state_d = LOAD;
      end
      LOAD:  if (is_pc) state_d = START;
      // Hold the start until every buffered INSTR has reached the imem.
      START: begin
        if (fifo_empty && !push) begin
          pc_wen_d = 1'b1;
          state_d  = RUN;
        end
      end
      RUN:   if (is_pc) state_d = START;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q     <= '0;
      fwd_q     <= '0;
      state_q   <= IDLE;
      pc_wen_q  <= 1'b0;
      rf_wen_q  <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      mask_q    <= '0;
      pc_q      <= '0;
      running_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pkt_q     <= net_packet_s'(net_packet_flat_i);
      fwd_q     <= fwd_d;
      state_q   <= state_d;
      pc_wen_q  <= pc_wen_d;
      running_q <= (state_d == RUN);
      rf_wen_q  <= is_reg & ~in_run;
      if (is_reg & ~in_run) begin
        rf_addr_q <= pkt_q.net_addr[rs_imm_size_gp-1:0];
        rf_data_q <= pkt_q.net_data;
      end
      if (is_bar) mask_q <= pkt_q.net_data[mask_length_gp-1:0];
      if (is_pc)  pc_q   <= pkt_q.net_data[imem_addr_width_p-1:0];
      if (drop | (in_run & (is_instr | is_reg))) err_q <= 1'b1;
    end
  end

`ifdef NET_RX_STATS_EN
  logic [15:0] icnt_q, rcnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      if (push & ~drop & (icnt_q != 16'hFFFF))
        icnt_q <= icnt_q + 16'd1;
      if (is_reg & ~in_run & (rcnt_q != 16'hFFFF))
        rcnt_q <= rcnt_q + 16'd1;
    end
  end

  assign instr_count_o = icnt_q;
  assign reg_count_o   = rcnt_q;
`else
  assign instr_count_o = '0;
  assign reg_count_o   = '0;
`endif

  assign net_packet_flat_o = fwd_q;
  assign imem_wen_o        = ~fifo_empty;
  assign imem_addr_o       = fifo_head[fw-1:iw];
  assign imem_data_o       = fifo_head[iw-1:0];
  assign rf_wen_o          = rf_wen_q;
  assign rf_addr_o         = rf_addr_q;
  assign rf_data_o         = rf_data_q;
  assign barrier_mask_o    = mask_q;
  assign pc_wen_o          = pc_wen_q;
  assign pc_o              = pc_q;
  assign running_o         = running_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_net_packet_rx.sv
// Directed self-checking bench for net_packet_rx.
// Counter checks expect live counts when NET_RX_STATS_EN is defined.
module tb_net_packet_rx;
  import net_packet_rx_pkg::*;

`ifdef NET_RX_STATS_EN
  localparam bit stats = 1'b1;
`else
  localparam bit stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdy = 1'b0;
  net_packet_s pin = '0;
  logic [$bits(net_packet_s)-1:0] pout;
  logic        imem_wen, rf_wen, pc_wen, running, err;
  logic [9:0]  imem_addr, pc;
  instruction_s imem_data;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [7:0]  mask;
  logic [15:0] icnt, rcnt;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  net_packet_rx dut (
    .clk               (clk),
    .reset             (reset),
    .net_packet_flat_i (pin),
    .net_packet_flat_o (pout),
    .imem_wen_o        (imem_wen),
    .imem_ready_i      (rdy),
    .imem_addr_o       (imem_addr),
    .imem_data_o       (imem_data),
    .rf_wen_o          (rf_wen),
    .rf_addr_o         (rf_addr),
    .rf_data_o         (rf_data),
    .barrier_mask_o    (mask),
    .pc_wen_o          (pc_wen),
    .pc_o              (pc),
    .running_o         (running),
    .err_o             (err),
    .instr_count_o     (icnt),
    .reg_count_o       (rcnt)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic net_packet_s mk(input logic [9:0] id,
                                     input net_op_e op,
                                     input logic [15:0] a,
                                     input logic [31:0] d);
    net_packet_s p;
    p.ID       = id;
    p.net_op   = op;
    p.net_addr = a;
    p.net_data = d;
    return p;
  endfunction

  task automatic cyc(input net_packet_s p);
    @(negedge clk);
    pin = p;
  endtask

  task automatic rst();
    @(negedge clk);
    reset = 1'b1;
    pin   = '0;
    rdy   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  net_packet_s fp;

  initial begin
    rst();
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_imem_wen", imem_wen, 0);
    chk("rst_pc_wen", pc_wen, 0);
    chk("rst_running", running, 0);
    chk("rst_err", err, 0);
    chk("rst_mask", mask, 0);
    chk("rst_pc", pc, 0);
    chk("rst_fwd", pout, 0);
    chk("rst_icnt", icnt, 0);

    // three back-to-back REG writes
    cyc(mk(10'd1, REG, 16'd1, 32'hA));
    cyc(mk(10'd1, REG, 16'd2, 32'hB));
    cyc(mk(10'd1, REG, 16'd3, 32'hC));
    for (int i = 0; i < 3; i++) begin
      chk("reg_wen", rf_wen, 1);
      chk("reg_addr", rf_addr, i + 1);
      chk("reg_data", rf_data, 32'hA + i);
      cyc('0);
    end
    chk("reg_wen_end", rf_wen, 0);
    chk("reg_err", err, 0);

    // overflow: six INSTR with imem stalled
    rst();
    for (int i = 0; i < 6; i++)
      cyc(mk(10'd1, INSTR, 16'(i), 32'h100 + i));
    chk("ovf_err_full", err, 0);
    for (int i = 0; i < 4; i++) cyc('0);
    chk("ovf_wen", imem_wen, 1);
    chk("ovf_err", err, 1);
    for (int i = 0; i < 4; i++) begin
      cyc('0);
      rdy = 1'b1;
      chk("ovf_addr", imem_addr, i);
      chk("ovf_data", imem_data, 16'h100 + i);
    end
    cyc('0);
    chk("ovf_drain", imem_wen, 0);

    // push and pop together on a full FIFO
    rst();
    for (int i = 0; i < 5; i++)
      cyc(mk(10'd1, INSTR, 16'(i), 32'h300 + i));
    cyc('0);
    rdy = 1'b1;
    cyc('0);
    chk("fullpp_err", err, 0);
    chk("fullpp_addr", imem_addr, 1);

    // load three INSTR then PC, imem ready toggling
    rst();
    for (int i = 0; i < 3; i++)
      cyc(mk(10'd1, INSTR, 16'(i), 32'h200 + i));
    cyc(mk(10'd1, PC, 16'd0, 32'd5));
    for (int n = 4; n < 12; n++) begin
      cyc('0);
      rdy = (n % 2 == 0);
      chk("pc_wen", pc_wen, (n == 10));
      if (n <= 8 && n % 2 == 0)
        chk("pc_imem_addr", imem_addr, n / 2 - 2);
    end
    chk("pc_val", pc, 5);
    chk("pc_running", running, 1);

    // foreign packet is forwarded, not decoded
    fp = mk(10'd2, REG, 16'd3, 32'hDEAD);
    cyc(fp);
    cyc('0);
    cyc('0);
    chk("fwd_pkt", pout, fp);
    chk("fwd_rf_wen", rf_wen, 0);
    cyc('0);
    chk("fwd_null", pout, 0);
    chk("fwd_err", err, 0);

    // BAR still works in RUN, REG is an error
    cyc(mk(10'd1, BAR, 16'd0, 32'h2));
    cyc('0);
    cyc('0);
    chk("bar_mask", mask, 2);
    chk("bar_err", err, 0);
    cyc(mk(10'd1, REG, 16'd4, 32'h7));
    cyc('0);
    cyc('0);
    chk("run_rf_wen", rf_wen, 0);
    chk("run_err", err, 1);

    // statistics and mid-stream reset
    rst();
    rdy = 1'b1;
    cyc(mk(10'd1, INSTR, 16'd0, 32'h1));
    cyc(mk(10'd1, INSTR, 16'd1, 32'h2));
    for (int i = 0; i < 3; i++)
      cyc(mk(10'd1, REG, 16'(i), 32'(i)));
    for (int i = 0; i < 3; i++) cyc('0);
    chk("st_icnt", icnt, stats ? 2 : 0);
    chk("st_rcnt", rcnt, stats ? 3 : 0);
    rdy = 1'b0;
    cyc(mk(10'd1, INSTR, 16'd5, 32'h9));
    cyc('0);
    cyc('0);
    chk("st_wen_pre", imem_wen, 1);
    #2 reset = 1'b1;
    #1;
    chk("st_icnt_rst", icnt, 0);
    chk("st_rcnt_rst", rcnt, 0);
    chk("st_fifo_rst", imem_wen, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc('0);
    chk("st_state_rst", running, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/net_packet_rx.md
# net_packet_rx

Network-side receiver that sits between the on-chip network and a core: it decodes incoming `net_packet_s` packets addressed to this core and turns them into instruction-memory, register-file, barrier-mask and PC-start write strobes. It is the receiving end of the boot/load protocol a host drives with INSTR, REG, BAR, PC and NULL packets. Packets for other IDs are forwarded unchanged on the outbound port one cycle later. INSTR writes are buffered so that a slow instruction memory does not lose packets.

## Interface
- `net_ID_p`, default `10'b1`: this core's network ID.
- `imem_addr_width_p`, default `imem_addr_width_gp`: instruction-memory address width.
- `fifo_depth_p`, default 4: number of INSTR buffer entries; must be a power of 2.

- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `net_packet_flat_i`, in, `$bits(net_packet_s)`: inbound packet, sampled every cycle, no backpressure.
- `net_packet_flat_o`, out, `$bits(net_packet_s)`: forwarded packet. Holds a non-matching packet, otherwise a NULL packet.
- `imem_wen_o`, out, 1: instruction write valid.
- `imem_ready_i`, in, 1: imem accepts the write this cycle.
- `imem_addr_o`, out, `imem_addr_width_p`: instruction address.
- `imem_data_o`, out, `$bits(instruction_s)`: instruction word.
- `rf_wen_o` / `rf_addr_o` / `rf_data_o`, out, 1 / `rs_imm_size_gp` / 32: register-file write.
- `barrier_mask_o`, out, `mask_length_gp`: barrier mask register.
- `pc_wen_o`, out, 1: one-cycle start pulse.
- `pc_o`, out, `imem_addr_width_p`: start PC.
- `running_o`, out, 1: the core has been released.
- `err_o`, out, 1: sticky protocol/overflow error.
- `instr_count_o`, `reg_count_o`, out, 16 each: statistics counters, present only when the statistics macro is defined.

## Operation
- Capture stage: `net_packet_flat_i` is registered every edge. A packet "matches" when `ID == net_ID_p` and `net_op != NULL`.
- Non-matching packet with `net_op != NULL`: copied to `net_packet_flat_o`. In every other case `net_packet_flat_o` carries a NULL packet.
- INSTR: pushes {`net_addr[imem_addr_width_p-1:0]`, `net_data[15:0]`} into the FIFO.
  - The FIFO head drives `imem_*`. `imem_wen_o` equals "FIFO not empty".
  - The head is popped on `imem_wen_o && imem_ready_i`.
  - A push while the FIFO is full and no pop occurs this cycle drops the packet and sets `err_o`.
  - A push and a pop in the same cycle on a full FIFO is legal and does not set `err_o`.
- REG: pulses `rf_wen_o` for one cycle with `rf_addr_o = net_addr[rs_imm_size_gp-1:0]` and `rf_data_o = net_data`.
- BAR: `barrier_mask_o <= net_data[mask_length_gp-1:0]`. The value persists until the next BAR packet or reset.
- PC: `pc_o <= net_data[imem_addr_width_p-1:0]` and sets `pending`.
- State machine:
  - IDLE: after reset. Moves to LOAD on the first matching INSTR, REG or BAR packet.
  - LOAD: moves to START on a PC packet. A PC packet received in IDLE also moves to START.
  - START: waits until the FIFO is empty. Then pulses `pc_wen_o` for one cycle and moves to RUN.
  - RUN: `running_o = 1`. Matching INSTR or REG packets are ignored and set `err_o`. A BAR packet still updates the mask. A further PC packet re-enters START.
- `err_o` is cleared only by reset.

## Timing
- Every output is registered.
- A packet on the input at edge N is captured at N.
  - REG: strobes visible after edge N+1.
  - INSTR: FIFO head visible after edge N+1, so minimum INSTR latency is 1 cycle.
  - BAR: mask updated after edge N+1.
  - Forward: `net_packet_flat_o` updated after edge N+1.
- PC with an empty FIFO: `pc_wen_o` is high for the cycle after edge N+2. With a non-empty FIFO, the pulse comes one cycle after the last pop.
- Reset values:
  - All strobes, `running_o`, `err_o`, FIFO occupancy and counters are 0.
  - `barrier_mask_o` = 0 and `pc_o` = 0.
  - `net_packet_flat_o` = NULL packet.
  - State = IDLE.
- Reset asserted mid-load discards FIFO contents and any pending PC.
- The FIFO pointers wrap modulo `fifo_depth_p`. The occupancy count is `$clog2(fifo_depth_p)+1` bits wide.

## Configuration
- `NET_RX_STATS_EN`:
  - Defined: `instr_count_o` and `reg_count_o` count accepted INSTR and REG packets in IDLE/LOAD/START. They saturate at `16'hFFFF` and reset to 0.
  - Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- The shared package (`definitions.v`) holds `net_packet_s`, the `net_op` enumeration (NULL, INSTR, REG, PC, BAR), `instruction_s`, `rs_imm_size_gp`, `mask_length_gp` and `imem_addr_width_gp`.
- A new enum `net_rx_state_e` {IDLE, LOAD, START, RUN} is added to the package.
- One sub-module: `net_rx_fifo`, a parameterised synchronous FIFO with width and depth parameters, push/pop, full/empty flags and an asynchronous active-high reset.

## Test plan
- Reset, then 3 REG packets (addr 1/2/3, data `32'hA`/`B`/`C`) -> three consecutive `rf_wen_o` pulses with matching addr/data. `err_o` = 0.
- 6 back-to-back INSTR packets, `imem_ready_i` = 0 for 10 cycles -> 4 entries held, the 5th and 6th are dropped, `err_o` = 1. After ready goes high, addresses 0..3 are written in order.
- INSTR packets for addr 0..2, then PC with `net_data = 5`, `imem_ready_i` toggling -> `pc_wen_o` pulses only after the third imem write, `pc_o = 5`, then `running_o` = 1.
- Packet with `ID = 10'd2`, op REG -> no `rf_wen_o`; `net_packet_flat_o` equals the packet one cycle later.
- BAR with `net_data = 32'h2` in RUN -> `barrier_mask_o = 2`. A REG packet in RUN -> no `rf_wen_o` and `err_o` = 1.
- With `NET_RX_STATS_EN`: 2 INSTR and 3 REG packets -> `instr_count_o = 2` and `reg_count_o = 3`. Reset asserted mid-stream -> both return to 0.
